// File: rtl/me_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : me_scan_ctrl_if
// Description : Row-read and SAD-return bus between the motion-estimation scan
//               sequencer (master) and the SAD datapath (slave).
//               rd_valid/dp_ready : row read handshake
//               addr/amt          : search BRAM row address, bank rotation
//               col_first         : first row of a candidate column
//               sad_valid/sad_in  : one candidate SAD returned by the datapath
// Revision    : 1.0 - initial release
// ============================================================================
interface me_scan_ctrl_if #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48,
    parameter int SAD_W      = 16
);
    localparam int c_PW   = MACRO_DIM + 1;
    localparam int c_AW   = $clog2(SEARCH_DIM * (SEARCH_DIM / MACRO_DIM));
    localparam int c_AMTW = $clog2(c_PW);

    logic              rd_valid;
    logic              dp_ready;
    logic [c_AW-1:0]   addr;
    logic [c_AMTW-1:0] amt;
    logic              col_first;
    logic              sad_valid;
    logic [SAD_W-1:0]  sad_in;

    modport master (
        output rd_valid, addr, amt, col_first,
        input  dp_ready, sad_valid, sad_in
    );

    modport slave (
        input  rd_valid, addr, amt, col_first,
        output dp_ready, sad_valid, sad_in
    );
endinterface
`default_nettype wire

// File: rtl/me_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : me_scan_ctrl
// Description : Full-search motion-estimation scan sequencer. Walks every
//               candidate column of the search window, streams the search
//               BRAM rows of each column to the SAD array, collects the
//               per-candidate SADs and tracks the minimum SAD and its motion
//               vector.
// Ports       : clk, rst_n (async, active-low)
//               start      - one-cycle pulse, begins a scan from IDLE
//               dp         - me_scan_ctrl_if master (row reads, SAD returns)
//               busy       - scan in progress
//               done       - one-cycle pulse, results final
//               min_sad    - best SAD
//               mv_x, mv_y - signed best offset
//               early_thr, early_hit - only with ME_EARLY_TERM_EN
// Options     : `define ME_EARLY_TERM_EN to stop the scan as soon as a SAD
//               below early_thr is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module me_scan_ctrl #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48,
    parameter int SAD_W      = 16,
    localparam int c_NCAND   = SEARCH_DIM - MACRO_DIM + 1,
    localparam int c_MVW     = $clog2(c_NCAND) + 1
) (
    input  wire                     clk,
    input  wire                     rst_n,
    input  wire                     start,
    me_scan_ctrl_if.master          dp,
    output logic                    busy,
    output logic                    done,
    output logic [SAD_W-1:0]        min_sad,
    output logic signed [c_MVW-1:0] mv_x,
    output logic signed [c_MVW-1:0] mv_y
`ifdef ME_EARLY_TERM_EN
    ,
    input  wire  [SAD_W-1:0]        early_thr,
    output logic                    early_hit
`endif
);
    // Number of search BRAM banks, address width and counter widths
    localparam int c_PW   = MACRO_DIM + 1;
    localparam int c_AW   = $clog2(SEARCH_DIM * (SEARCH_DIM / MACRO_DIM));
    localparam int c_AMTW = $clog2(c_PW);
    localparam int c_XW   = $clog2(c_NCAND);
    localparam int c_RW   = $clog2(SEARCH_DIM);
    localparam int c_CW   = $clog2(c_NCAND + 1);
    localparam int c_HALF = (c_NCAND - 1) / 2;

    localparam logic [c_XW-1:0]   c_X_LAST    = c_XW'(c_NCAND - 1);
    localparam logic [c_RW-1:0]   c_ROW_LAST  = c_RW'(SEARCH_DIM - 1);
    localparam logic [c_CW-1:0]   c_CNT_FULL  = c_CW'(c_NCAND);
    localparam logic [c_AMTW-1:0] c_AMT_LAST  = c_AMTW'(c_PW - 1);
    localparam logic [c_AW-1:0]   c_BANK_STEP = c_AW'(SEARCH_DIM);
    localparam logic [c_MVW-1:0]  c_MV_OFS    = c_MVW'(c_HALF);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SCAN = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    logic [1:0]              r_state;
    logic [c_XW-1:0]         r_x;        // candidate column
    logic [c_RW-1:0]         r_row;      // row within the column
    logic [c_CW-1:0]         r_res_cnt;  // results collected for column r_x
    logic [c_AW-1:0]         r_base;     // (x / PORT_WIDTH) * SEARCH_DIM
    logic [c_AMTW-1:0]       r_amt;      // x % PORT_WIDTH
    logic [SAD_W-1:0]        r_min;
    logic signed [c_MVW-1:0] r_mv_x;
    logic signed [c_MVW-1:0] r_mv_y;

    logic            w_scan;
    logic            w_wait;
    logic            w_xfer;
    logic            w_accept;
    logic [c_CW-1:0] w_cnt_next;
    logic            w_col_done;
    logic            w_early;
    logic            w_take;

    assign w_scan     = (r_state == c_ST_SCAN);
    assign w_wait     = (r_state == c_ST_WAIT);
    assign w_xfer     = w_scan && dp.dp_ready;
    // Results beyond the column's candidate count are dropped
    assign w_accept   = dp.sad_valid && (w_scan || w_wait) && (r_res_cnt != c_CNT_FULL);
    assign w_cnt_next = r_res_cnt + c_CW'(w_accept);
    // Uses the post-increment count so the final result and the exit
    // decision land in the same cycle
    assign w_col_done = w_wait && (w_cnt_next == c_CNT_FULL);

`ifdef ME_EARLY_TERM_EN
    assign w_early    = w_accept && (dp.sad_in < early_thr);
`else
    assign w_early    = 1'b0;
`endif
    // Strict compare keeps the earliest candidate on ties
    assign w_take     = w_accept && ((dp.sad_in < r_min) || w_early);

    // The base/rotation registers make the row address a single add
    assign dp.rd_valid  = w_scan;
    assign dp.addr      = w_scan ? (r_base + c_AW'(r_row)) : '0;
    assign dp.amt       = w_scan ? r_amt : '0;
    assign dp.col_first = w_scan && (r_row == '0);

    assign busy    = w_scan || w_wait;
    assign done    = (r_state == c_ST_DONE);
    assign min_sad = r_min;
    assign mv_x    = r_mv_x;
    assign mv_y    = r_mv_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_x       <= '0;
            r_row     <= '0;
            r_res_cnt <= '0;
            r_base    <= '0;
            r_amt     <= '0;
            r_min     <= '0;
            r_mv_x    <= '0;
            r_mv_y    <= '0;
`ifdef ME_EARLY_TERM_EN
            early_hit <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_res_cnt <= w_cnt_next;
                if (w_take) begin
                    r_min  <= dp.sad_in;
                    r_mv_x <= c_MVW'(r_x) - c_MV_OFS;
                    r_mv_y <= c_MVW'(r_res_cnt) - c_MV_OFS;
                end
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_x       <= '0;
                        r_row     <= '0;
                        r_res_cnt <= '0;
                        r_base    <= '0;
                        r_amt     <= '0;
                        r_min     <= '1;
                        r_mv_x    <= '0;
                        r_mv_y    <= '0;
`ifdef ME_EARLY_TERM_EN
                        early_hit <= 1'b0;
`endif
                        r_state   <= c_ST_SCAN;
                    end
                end
                c_ST_SCAN: begin
                    if (w_xfer) begin
                        if (r_row == c_ROW_LAST) begin
                            r_row   <= '0;
                            r_state <= c_ST_WAIT;
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (w_col_done) begin
                        if (r_x == c_X_LAST) begin
                            r_state <= c_ST_DONE;
                        end else begin
                            r_x       <= r_x + 1'b1;
                            r_row     <= '0;
                            r_res_cnt <= '0;
                            r_state   <= c_ST_SCAN;
                            // Wrapping the rotation moves to the next bank row block
                            if (r_amt == c_AMT_LAST) begin
                                r_amt  <= '0;
                                r_base <= r_base + c_BANK_STEP;
                            end else begin
                                r_amt <= r_amt + 1'b1;
                            end
                        end
                    end
                end
                c_ST_DONE: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase

`ifdef ME_EARLY_TERM_EN
            // Abandons the read stream regardless of the current state
            if (w_early) begin
                r_state   <= c_ST_DONE;
                early_hit <= 1'b1;
            end
`endif
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_me_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_me_scan_ctrl
// Description : Self-checking bench for me_scan_ctrl. A scan driver plays the
//               datapath (random backpressure, SAD return queue), and a
//               table-walking reference model provides the expected best
//               candidate.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_me_scan_ctrl;
    localparam int MD     = 16;
    localparam int SD     = 48;
    localparam int SW     = 16;
    localparam int NC     = SD - MD + 1;
    localparam int PW     = MD + 1;
    localparam int MVW    = $clog2(NC) + 1;
    localparam int HALF   = (NC - 1) / 2;
    localparam int NXFER  = NC * SD;
    localparam int BUDGET = 12000;

    logic                  clk   = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic                  busy;
    logic                  done;
    logic [SW-1:0]         min_sad;
    logic signed [MVW-1:0] mv_x;
    logic signed [MVW-1:0] mv_y;
`ifdef ME_EARLY_TERM_EN
    logic [SW-1:0]         early_thr = '0;
    logic                  early_hit;
`endif

    me_scan_ctrl_if #(.MACRO_DIM(MD), .SEARCH_DIM(SD), .SAD_W(SW)) bus ();

    me_scan_ctrl #(.MACRO_DIM(MD), .SEARCH_DIM(SD), .SAD_W(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dp        (bus),
        .busy      (busy),
        .done      (done),
        .min_sad   (min_sad),
        .mv_x      (mv_x),
        .mv_y      (mv_y)
`ifdef ME_EARLY_TERM_EN
        ,
        .early_thr (early_thr),
        .early_hit (early_hit)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int sad_tab [NC][NC];
    int seq_q[$];
    int ref_q[$];
    int xfer_cnt, seq_bad, stab_bad, busy_bad, done_cnt;
    int c17_addr, c17_amt, hit_val, hit_cyc, done_cyc;
    bit timed_out, aborted, busy_at_done;
    int em, ex, ey;

    task automatic fill(input int v);
        for (int x = 0; x < NC; x++)
            for (int y = 0; y < NC; y++)
                sad_tab[x][y] = v;
    endtask

    task automatic fill_random();
        for (int x = 0; x < NC; x++)
            for (int y = 0; y < NC; y++)
                sad_tab[x][y] = int'($urandom_range(200, 60000));
        em = int'($urandom_range(1, 199));
        sad_tab[$urandom_range(0, NC-1)][$urandom_range(0, NC-1)] = em;
        sad_tab[$urandom_range(0, NC-1)][$urandom_range(0, NC-1)] = em;
    endtask

    // Walk candidates in scan order (x-major, then y); first strict minimum wins
    task automatic model_best(output int bmin, output int bx, output int by);
        bit stop;
        bit hit;
        stop = 1'b0;
        bmin = (1 << SW) - 1;
        bx = 0;
        by = 0;
        for (int x = 0; x < NC; x++)
            for (int y = 0; y < NC; y++)
                if (!stop) begin
                    hit = 1'b0;
`ifdef ME_EARLY_TERM_EN
                    hit = (sad_tab[x][y] < int'(early_thr));
`endif
                    if (sad_tab[x][y] < bmin || hit) begin
                        bmin = sad_tab[x][y];
                        bx   = x - HALF;
                        by   = y - HALF;
                    end
                    if (hit) stop = 1'b1;
                end
    endtask

    // Plays the datapath for one scan. bp: random dp_ready and result gaps.
    // proto: column 5 results (plus 5 surplus zeros) returned during its
    // reads, and a stray start pulse. abort_col >= 0: assert reset mid-column.
    task automatic run_scan(input bit bp, input bit proto, input int abort_col);
        int  q[$];
        bit  prev_stall, ready, fin;
        int  p_addr, p_amt, col, row, v;
        bit  p_cf;
        prev_stall = 1'b0; fin = 1'b0; p_addr = 0; p_amt = 0; p_cf = 1'b0;
        xfer_cnt = 0; seq_bad = 0; stab_bad = 0; busy_bad = 0; done_cnt = 0;
        timed_out = 1'b0; aborted = 1'b0; busy_at_done = 1'b0;
        c17_addr = -1; c17_amt = -1; hit_cyc = -1; done_cyc = -1;
        seq_q.delete();
        bus.dp_ready = 1'b0; bus.sad_valid = 1'b0; bus.sad_in = '0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int cyc = 0; cyc < BUDGET && !fin; cyc++) begin
            if (prev_stall && (int'(bus.addr) != p_addr || int'(bus.amt) != p_amt
                               || bus.col_first != p_cf))
                stab_bad++;
            if (done) begin
                done_cnt++; done_cyc = cyc; busy_at_done = busy; fin = 1'b1;
            end else if (abort_col >= 0 && xfer_cnt == abort_col * SD + 20) begin
                rst_n = 1'b0; aborted = 1'b1; fin = 1'b1;
            end else begin
                if (busy !== 1'b1) busy_bad++;
                ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.dp_ready = ready;
                prev_stall = bus.rd_valid && !ready;
                p_addr = int'(bus.addr); p_amt = int'(bus.amt); p_cf = bus.col_first;
                if (bus.rd_valid && ready) begin
                    col = xfer_cnt / SD;
                    row = xfer_cnt % SD;
                    if (int'(bus.addr) != (col / PW) * SD + row || int'(bus.amt) != col % PW
                        || bus.col_first != (row == 0))
                        seq_bad++;
                    seq_q.push_back(int'(bus.addr) * 64 + int'(bus.amt));
                    if (col == 17 && row == 0) begin
                        c17_addr = int'(bus.addr); c17_amt = int'(bus.amt);
                    end
                    if (proto && col == 5) begin
                        if (row == 0) begin
                            for (int y = 0; y < NC; y++) q.push_back(sad_tab[col][y]);
                            for (int k = 0; k < 5; k++) q.push_back(0);
                        end
                    end else if (row == SD - 1) begin
                        for (int y = 0; y < NC; y++) q.push_back(sad_tab[col][y]);
                    end
                    xfer_cnt++;
                end
                if (q.size() > 0 && (!bp || $urandom_range(0, 3) != 0)) begin
                    v = q.pop_front();
                    if (v == hit_val) hit_cyc = cyc;
                    bus.sad_valid = 1'b1; bus.sad_in = SW'(v);
                end else begin
                    bus.sad_valid = 1'b0; bus.sad_in = '0;
                end
                start = proto && (cyc == 300);
                @(negedge clk);
            end
        end
        bus.sad_valid = 1'b0; bus.dp_ready = 1'b0; start = 1'b0;
        if (!fin) begin
            timed_out = 1'b1;
            $display("FAIL scan_timeout: got no done after %0d cycles, expected done", BUDGET);
            rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
        end
        if (!aborted) begin
            // sad_valid in DONE/IDLE must be ignored
            repeat (5) begin
                bus.sad_valid = 1'b1; bus.sad_in = '0;
                @(negedge clk);
                if (done) done_cnt++;
            end
            bus.sad_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if ({bus.rd_valid, bus.col_first, bus.addr, bus.amt} !== '0) begin errors++;
            $display("FAIL reset_bus: got %0h expected 0", {bus.rd_valid, bus.col_first, bus.addr, bus.amt}); end
        checks++; if ({busy, done} !== 2'b00) begin errors++;
            $display("FAIL reset_status: got %b expected 00", {busy, done}); end
        checks++; if ({min_sad, mv_x, mv_y} !== '0) begin errors++;
            $display("FAIL reset_result: got %0h expected 0", {min_sad, mv_x, mv_y}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_planted();
        fill(1000); sad_tab[20][5] = 37; hit_val = -1;
        run_scan(1'b0, 1'b0, -1);
        model_best(em, ex, ey);
        ref_q = seq_q;
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL planted_done_cnt: got %0d expected 1", done_cnt); end
        checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL planted_busy_at_done: got %0d expected 0", busy_at_done); end
        checks++; if (busy_bad !== 0) begin errors++; $display("FAIL planted_busy: got %0d low cycles expected 0", busy_bad); end
        checks++; if (xfer_cnt !== NXFER) begin errors++; $display("FAIL planted_xfers: got %0d expected %0d", xfer_cnt, NXFER); end
        checks++; if (seq_bad !== 0) begin errors++; $display("FAIL planted_addr_seq: got %0d bad expected 0", seq_bad); end
        checks++; if (int'(min_sad) !== em) begin errors++; $display("FAIL planted_min: got %0d expected %0d", min_sad, em); end
        checks++; if (int'(mv_x) !== ex || int'(mv_y) !== ey) begin errors++;
            $display("FAIL planted_mv: got (%0d,%0d) expected (%0d,%0d)", mv_x, mv_y, ex, ey); end
    endtask

    task automatic test_tie();
        fill(900); sad_tab[3][3] = 50; sad_tab[10][10] = 50; hit_val = -1;
        run_scan(1'b0, 1'b0, -1);
        model_best(em, ex, ey);
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL tie_done_cnt: got %0d expected 1", done_cnt); end
        checks++; if (int'(min_sad) !== em) begin errors++; $display("FAIL tie_min: got %0d expected %0d", min_sad, em); end
        checks++; if (int'(mv_x) !== ex || int'(mv_y) !== ey) begin errors++;
            $display("FAIL tie_mv: got (%0d,%0d) expected (%0d,%0d)", mv_x, mv_y, ex, ey); end
    endtask

    task automatic test_backpressure();
        int diff;
        fill(1000); sad_tab[20][5] = 37; hit_val = -1;
        run_scan(1'b1, 1'b0, -1);
        model_best(em, ex, ey);
        diff = (seq_q.size() == ref_q.size()) ? 0 : 1;
        if (diff == 0) for (int i = 0; i < seq_q.size(); i++) if (seq_q[i] != ref_q[i]) diff++;
        checks++; if (diff !== 0) begin errors++; $display("FAIL bp_seq_vs_ready_run: got %0d differences expected 0", diff); end
        checks++; if (stab_bad !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes under stall expected 0", stab_bad); end
        checks++; if (c17_addr !== 48 || c17_amt !== 0) begin errors++;
            $display("FAIL bp_col17_start: got addr %0d amt %0d expected addr 48 amt 0", c17_addr, c17_amt); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bp_done_cnt: got %0d expected 1", done_cnt); end
        checks++; if (int'(min_sad) !== em || int'(mv_x) !== ex || int'(mv_y) !== ey) begin errors++;
            $display("FAIL bp_result: got %0d (%0d,%0d) expected %0d (%0d,%0d)", min_sad, mv_x, mv_y, em, ex, ey); end
    endtask

    task automatic test_protocol();
        fill(1000); sad_tab[20][5] = 37; hit_val = -1;
        run_scan(1'b0, 1'b1, -1);
        model_best(em, ex, ey);
        checks++; if (xfer_cnt !== NXFER || seq_bad !== 0) begin errors++;
            $display("FAIL proto_no_restart: got %0d xfers %0d bad expected %0d xfers 0 bad", xfer_cnt, seq_bad, NXFER); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL proto_done_cnt: got %0d expected 1", done_cnt); end
        checks++; if (int'(min_sad) !== em || int'(mv_x) !== ex || int'(mv_y) !== ey) begin errors++;
            $display("FAIL proto_result: got %0d (%0d,%0d) expected %0d (%0d,%0d)", min_sad, mv_x, mv_y, em, ex, ey); end
    endtask

    task automatic test_reset_midscan();
        int late_done;
        late_done = 0;
        fill_random(); hit_val = -1;
        run_scan(1'b1, 1'b0, 9);
        checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL rst_reached_col9: got %0d expected 1", aborted); end
        #1;
        checks++; if ({bus.rd_valid, bus.col_first, bus.addr, bus.amt, busy, done} !== '0) begin errors++;
            $display("FAIL rst_mid_outputs: got %0h expected 0", {bus.rd_valid, bus.col_first, bus.addr, bus.amt, busy, done}); end
        checks++; if ({min_sad, mv_x, mv_y} !== '0) begin errors++;
            $display("FAIL rst_mid_result: got %0h expected 0", {min_sad, mv_x, mv_y}); end
        repeat (3) begin @(negedge clk); if (done) late_done++; end
        rst_n = 1'b1;
        repeat (2) begin @(negedge clk); if (done) late_done++; end
        checks++; if (late_done !== 0) begin errors++; $display("FAIL rst_no_done: got %0d pulses expected 0", late_done); end
        fill_random();
        run_scan(1'b1, 1'b0, -1);
        model_best(em, ex, ey);
        checks++; if (done_cnt !== 1 || xfer_cnt !== NXFER) begin errors++;
            $display("FAIL rst_rescan: got %0d done %0d xfers expected 1 done %0d xfers", done_cnt, xfer_cnt, NXFER); end
        checks++; if (int'(min_sad) !== em || int'(mv_x) !== ex || int'(mv_y) !== ey) begin errors++;
            $display("FAIL rst_rescan_result: got %0d (%0d,%0d) expected %0d (%0d,%0d)", min_sad, mv_x, mv_y, em, ex, ey); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            fill_random(); hit_val = -1;
            run_scan(1'b1, 1'b0, -1);
            model_best(em, ex, ey);
            checks++; if (done_cnt !== 1 || seq_bad !== 0 || stab_bad !== 0) begin errors++;
                $display("FAIL rand_protocol: got done %0d seq_bad %0d stab_bad %0d expected 1 0 0", done_cnt, seq_bad, stab_bad); end
            checks++; if (int'(min_sad) !== em || int'(mv_x) !== ex || int'(mv_y) !== ey) begin errors++;
                $display("FAIL rand_result: got %0d (%0d,%0d) expected %0d (%0d,%0d)", min_sad, mv_x, mv_y, em, ex, ey); end
        end
    endtask

`ifdef ME_EARLY_TERM_EN
    task automatic test_early();
        fill(1000); sad_tab[2][7] = 12; early_thr = 20; hit_val = 12;
        run_scan(1'b0, 1'b0, -1);
        model_best(em, ex, ey);
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL early_done_cnt: got %0d expected 1", done_cnt); end
        checks++; if (done_cyc - hit_cyc !== 1) begin errors++;
            $display("FAIL early_latency: got %0d cycles expected 1", done_cyc - hit_cyc); end
        checks++; if (early_hit !== 1'b1) begin errors++; $display("FAIL early_hit_set: got %0d expected 1", early_hit); end
        checks++; if (int'(min_sad) !== em || int'(mv_x) !== ex || int'(mv_y) !== ey) begin errors++;
            $display("FAIL early_result: got %0d (%0d,%0d) expected %0d (%0d,%0d)", min_sad, mv_x, mv_y, em, ex, ey); end
        early_thr = '0; hit_val = -1;
        fill(1000); sad_tab[20][5] = 37;
        run_scan(1'b0, 1'b0, -1);
        checks++; if (early_hit !== 1'b0 || xfer_cnt !== NXFER) begin errors++;
            $display("FAIL early_off: got hit %0d xfers %0d expected 0 %0d", early_hit, xfer_cnt, NXFER); end
    endtask
`endif

    initial begin
        bus.dp_ready  = 1'b0;
        bus.sad_valid = 1'b0;
        bus.sad_in    = '0;
        hit_val       = -1;
        test_reset();
        test_planted();
        test_tie();
        test_backpressure();
        test_protocol();
        test_reset_midscan();
        test_random();
`ifdef ME_EARLY_TERM_EN
        test_early();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
